// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load alignment/extension, load-wait stalling,
// misaligned-load detection and a sticky memory-timeout flag.
module mem_wb_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_pc4,
  input  logic [31:0] m_imm,
  input  logic [1:0]  m_wbsel,
  input  logic        m_regwr,
  input  logic [4:0]  m_rd,
  input  logic [1:0]  m_lsize,
  input  logic        m_lunsigned,
  input  logic        hold,
  input  logic        flush,
  output logic        mem_stall,
  output logic [31:0] wb_a,
  output logic [31:0] wb_b,
  output logic [31:0] wb_c,
  output logic [31:0] wb_d,
  output logic [1:0]  wb_sel,
  output logic        wb_regwr,
  output logic [4:0]  wb_rd,
  output logic        wb_valid,
  output logic        misalign,
  output logic        mem_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0]  wait_cnt;
  logic [7:0]  wait_inc;
  logic [1:0]  off;
  logic [7:0]  lane [0:3];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        is_load;
  logic        misaligned;
  logic        bad_load;
  logic        wr_ok;

  assign off = m_alu[1:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = m_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel  = lane[off];
    half_sel  = off[1] ? m_rdata[31:16] : m_rdata[15:0];
    load_data = m_rdata;
    case (m_lsize)
      2'b10:   load_data = {{24{~m_lunsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~m_lunsigned & half_sel[15]}}, half_sel};
      default: load_data = m_rdata;
    endcase
  end

  // Reserved size 11 is checked like a word access.
  always_comb begin
    misaligned = 1'b0;
    case (m_lsize)
      2'b10:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  end

  assign is_load   = m_valid & (m_wbsel == 2'b01);
  assign bad_load  = is_load & misaligned;
  assign mem_stall = is_load & ~m_rvalid & ~flush;
  assign wr_ok     = m_valid & m_regwr & (m_rd != 5'd0) & ~bad_load;
  assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_a        <= '0;
      wb_b        <= '0;
      wb_c        <= '0;
      wb_d        <= '0;
      wb_sel      <= '0;
      wb_rd       <= '0;
      wb_regwr    <= 1'b0;
      wb_valid    <= 1'b0;
      misalign    <= 1'b0;
      mem_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_regwr <= 1'b0;
      misalign <= 1'b0;
    end else if (hold) begin
      misalign <= 1'b0;
    end else if (mem_stall) begin
      // Bubble into WB while the read data is outstanding.
      wb_valid <= 1'b0;
      wb_regwr <= 1'b0;
      misalign <= 1'b0;
      wait_cnt <= wait_inc;
      if (wait_inc >= TIMEOUT_CNT) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wb_a     <= m_alu;
      wb_b     <= bad_load ? m_rdata : load_data;
      wb_c     <= m_pc4;
      wb_d     <= m_imm;
      wb_sel   <= m_wbsel;
      wb_rd    <= m_rd;
      wb_valid <= m_valid;
      wb_regwr <= wr_ok;
      misalign <= bad_load;
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage, checked against a
// behavioural model of the write-back stage.
module tb_mem_wb_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_alu = '0;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_pc4 = '0;
  logic [31:0] m_imm = '0;
  logic [1:0]  m_wbsel = '0;
  logic        m_regwr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_lsize = '0;
  logic        m_lunsigned = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        mem_stall;
  logic [31:0] wb_a, wb_b, wb_c, wb_d;
  logic [1:0]  wb_sel;
  logic        wb_regwr, wb_valid, misalign, mem_timeout;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // behavioural model state
  logic [31:0] e_a, e_b, e_c, e_d;
  logic [1:0]  e_sel;
  logic [4:0]  e_rd;
  logic        e_regwr, e_valid, e_mis, e_to;
  int          e_cnt;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_alu(m_alu),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_pc4(m_pc4), .m_imm(m_imm),
    .m_wbsel(m_wbsel), .m_regwr(m_regwr), .m_rd(m_rd), .m_lsize(m_lsize),
    .m_lunsigned(m_lunsigned), .hold(hold), .flush(flush),
    .mem_stall(mem_stall), .wb_a(wb_a), .wb_b(wb_b), .wb_c(wb_c), .wb_d(wb_d),
    .wb_sel(wb_sel), .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_valid(wb_valid),
    .misalign(misalign), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int ofs,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b10) begin
      v = (rd >> (8 * ofs)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * (ofs / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic ref_misaligned(input int ofs, input logic [1:0] sz);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return (ofs % 2) != 0;
    return ofs != 0;
  endfunction

  function automatic logic ref_stall();
    return m_valid && m_wbsel == 2'b01 && !m_rvalid && !flush;
  endfunction

  task automatic model_reset();
    e_a = 0; e_b = 0; e_c = 0; e_d = 0; e_sel = 0; e_rd = 0;
    e_regwr = 0; e_valid = 0; e_mis = 0; e_to = 0; e_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic rv, input logic [1:0] sel, input logic wr,
                       input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                       input logic h, input logic f);
    m_valid = v; m_alu = alu; m_rdata = rdata; m_rvalid = rv; m_wbsel = sel;
    m_regwr = wr; m_rd = rd; m_lsize = sz; m_lunsigned = uns; hold = h; flush = f;
    m_pc4 = $urandom; m_imm = $urandom;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    int ofs;
    logic ld, bad;
    ofs = int'(m_alu[1:0]);
    ld  = m_valid && m_wbsel == 2'b01;
    bad = ld && ref_misaligned(ofs, m_lsize);
    if (flush) begin
      e_valid = 0; e_regwr = 0; e_mis = 0;
    end else if (hold) begin
      e_mis = 0;
    end else if (ref_stall()) begin
      e_valid = 0; e_regwr = 0; e_mis = 0;
      e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
      if (e_cnt >= TO) e_to = 1;
    end else begin
      e_a = m_alu; e_c = m_pc4; e_d = m_imm; e_sel = m_wbsel; e_rd = m_rd;
      e_b = bad ? m_rdata : ref_load(m_rdata, ofs, m_lsize, m_lunsigned);
      e_valid = m_valid;
      e_regwr = m_valid && m_regwr && m_rd != 0 && !bad;
      e_mis = bad;
      e_cnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: v=%0b sel=%0d rd=%0d wr=%0b a=%h b=%h mis=%0b to=%0b",
             cyc, wb_valid, wb_sel, wb_rd, wb_regwr, wb_a, wb_b, misalign, mem_timeout);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #3;
    checks++;
    if ({wb_a, wb_b, wb_c, wb_d} !== 128'd0 || wb_sel !== 2'd0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL reset_data: got a=%h b=%h c=%h d=%h sel=%0d rd=%0d want zeros",
                         wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd);
    end
    checks++;
    if ({wb_regwr, wb_valid, misalign, mem_timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
                         {wb_regwr, wb_valid, misalign, mem_timeout});
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_alu_op();
    drive(1, 32'h12345678, 32'h0, 0, 2'b00, 1, 5'd5, 2'b00, 0, 0, 0);
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL alu_nostall: got %0b want 0", mem_stall);
    end
    step();
    checks++;
    if (wb_a !== 32'h12345678 || wb_sel !== 2'b00 || wb_rd !== 5'd5 ||
        wb_regwr !== 1'b1 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL alu_op: got a=%h sel=%0d rd=%0d wr=%0b v=%0b want 12345678/0/5/1/1",
                         wb_a, wb_sel, wb_rd, wb_regwr, wb_valid);
    end
    // asynchronous reset in mid-cycle clears at once
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_a !== 32'd0) begin
      errors++; $display("FAIL async_reset: got v=%0b a=%h want 0/0", wb_valid, wb_a);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_byte_load();
    drive(1, 32'h1003, 32'h80FF0000, 1, 2'b01, 1, 5'd7, 2'b10, 0, 0, 0);
    step();
    checks++;
    if (wb_b !== 32'hFFFFFF80 || wb_valid !== 1'b1 || wb_regwr !== 1'b1) begin
      errors++; $display("FAIL byte_signed: got b=%h v=%0b wr=%0b want ffffff80/1/1",
                         wb_b, wb_valid, wb_regwr);
    end
    drive(1, 32'h1003, 32'h80FF0000, 1, 2'b01, 1, 5'd7, 2'b10, 1, 0, 0);
    step();
    checks++;
    if (wb_b !== 32'h00000080) begin
      errors++; $display("FAIL byte_unsigned: got b=%h want 00000080", wb_b);
    end
  endtask

  task automatic test_half_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h2002, 32'hBEEF1234, 0, 2'b01, 1, 5'd3, 2'b01, 0, 0, 0);
      checks++;
      if (mem_stall !== 1'b1) begin
        errors++; $display("FAIL half_stall%0d: got %0b want 1", i, mem_stall);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0 || wb_regwr !== 1'b0) begin
        errors++; $display("FAIL half_bubble%0d: got v=%0b wr=%0b want 0/0", i, wb_valid, wb_regwr);
      end
    end
    drive(1, 32'h2002, 32'hBEEF1234, 1, 2'b01, 1, 5'd3, 2'b01, 0, 0, 0);
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL half_release: got %0b want 0", mem_stall);
    end
    step();
    checks++;
    if (wb_b !== 32'hFFFFBEEF || wb_valid !== 1'b1 || wb_rd !== 5'd3) begin
      errors++; $display("FAIL half_capture: got b=%h v=%0b rd=%0d want ffffbeef/1/3",
                         wb_b, wb_valid, wb_rd);
    end
  endtask

  task automatic test_misalign();
    drive(1, 32'h3001, 32'hCAFEF00D, 1, 2'b01, 1, 5'd9, 2'b00, 0, 0, 0);
    step();
    checks++;
    if (misalign !== 1'b1 || wb_regwr !== 1'b0 || wb_valid !== 1'b1 || wb_b !== 32'hCAFEF00D) begin
      errors++; $display("FAIL misalign: got mis=%0b wr=%0b v=%0b b=%h want 1/0/1/cafef00d",
                         misalign, wb_regwr, wb_valid, wb_b);
    end
    drive(0, 32'h0, 32'h0, 0, 2'b00, 0, 5'd0, 2'b00, 0, 0, 0);
    step();
    checks++;
    if (misalign !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: got mis=%0b v=%0b want 0/0", misalign, wb_valid);
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h4000, 32'h11111111, 1, 2'b01, 1, 5'd4, 2'b00, 0, 1, 1);
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %0b want 0", mem_stall);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0 || wb_regwr !== 1'b0) begin
      errors++; $display("FAIL flush: got v=%0b wr=%0b want 0/0", wb_valid, wb_regwr);
    end
    drive(1, 32'hA5A5A5A5, 32'h0, 0, 2'b00, 1, 5'd0, 2'b00, 0, 0, 0);
    step();
    checks++;
    if (wb_regwr !== 1'b0 || wb_valid !== 1'b1 || wb_a !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rd0: got wr=%0b v=%0b a=%h want 0/1/a5a5a5a5", wb_regwr, wb_valid, wb_a);
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= TO; i++) begin
      drive(1, 32'h5000, 32'h0, 0, 2'b01, 1, 5'd6, 2'b00, 0, 0, 0);
      step();
      if (i == TO - 1) begin
        checks++;
        if (mem_timeout !== 1'b0) begin
          errors++; $display("FAIL timeout_early: got %0b want 0 after %0d waits", mem_timeout, i);
        end
      end
    end
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got %0b want 1", mem_timeout);
    end
    drive(1, 32'h5000, 32'h76543210, 1, 2'b01, 1, 5'd6, 2'b00, 0, 0, 0);
    step();
    checks++;
    if (mem_timeout !== 1'b1 || wb_valid !== 1'b1 || wb_b !== 32'h76543210) begin
      errors++; $display("FAIL timeout_sticky: got to=%0b v=%0b b=%h want 1/1/76543210",
                         mem_timeout, wb_valid, wb_b);
    end
    // reset in the middle of another load-wait abandons it
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h6000, 32'h0, 0, 2'b01, 1, 5'd2, 2'b00, 0, 0, 0);
      step();
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (mem_timeout !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_reset: got to=%0b v=%0b want 0/0", mem_timeout, wb_valid);
    end
    @(posedge clk); #1;
    rst_n = 1;
    drive(1, 32'h6000, 32'h0000ABCD, 1, 2'b01, 1, 5'd2, 2'b01, 1, 0, 0);
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_b !== 32'h0000ABCD || mem_timeout !== 1'b0 || wb_regwr !== 1'b1) begin
      errors++; $display("FAIL post_reset_load: got v=%0b b=%h to=%0b wr=%0b want 1/0000abcd/0/1",
                         wb_valid, wb_b, mem_timeout, wb_regwr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 9) < 7,
            2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      checks++;
      if (mem_stall !== ref_stall()) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, mem_stall, ref_stall());
      end
      step();
      checks++;
      if (wb_a !== e_a || wb_b !== e_b || wb_c !== e_c || wb_d !== e_d ||
          wb_sel !== e_sel || wb_rd !== e_rd) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h %h %h %h %0d %0d want %h %h %h %h %0d %0d",
                           n, wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd, e_a, e_b, e_c, e_d, e_sel, e_rd);
      end
      checks++;
      if ({wb_valid, wb_regwr, misalign, mem_timeout} !== {e_valid, e_regwr, e_mis, e_to}) begin
        errors++; $display("FAIL rnd_flags[%0d]: got %b want %b", n,
                           {wb_valid, wb_regwr, misalign, mem_timeout}, {e_valid, e_regwr, e_mis, e_to});
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_byte_load();
    test_half_stall();
    test_misalign();
    test_flush();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum load-wait cycles before timeout flag (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 m_valid  in  1  MEM-stage instruction valid.
REQ-005 m_alu  in  32  ALU result; bits [1:0] are load byte offset.
REQ-006 m_rdata  in  32  raw data-memory read word.
REQ-007 m_rvalid  in  1  data memory read data valid this cycle.
REQ-008 m_pc4  in  32  PC+4 of instruction.
REQ-009 m_imm  in  32  upper-immediate value.
REQ-010 m_wbsel  in  2  write-back select (00 ALU, 01 load, 10 PC+4, 11 imm).
REQ-011 m_regwr  in  1  register write enable.
REQ-012 m_rd  in  5  destination register.
REQ-013 m_lsize  in  2  load size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-014 m_lunsigned  in  1  1 = zero-extend, 0 = sign-extend.
REQ-015 hold  in  1  downstream hold; freeze all WB registers.
REQ-016 flush  in  1  kill WB-stage contents.
REQ-017 mem_stall  out  1  combinational; upstream must hold MEM stage.
REQ-018 wb_a, wb_b, wb_c, wb_d  out  32 each  registered ALU, aligned load, PC+4, imm (write-back mux channels A..D).
REQ-019 wb_sel  out  2  registered m_wbsel.
REQ-020 wb_regwr  out  1  registered, qualified write enable.
REQ-021 wb_rd  out  5  registered destination.
REQ-022 wb_valid  out  1  WB-stage instruction valid.
REQ-023 misalign  out  1  one-cycle pulse on misaligned load.
REQ-024 mem_timeout  out  1  sticky timeout flag.

Function
REQ-025 A load is m_valid=1 with m_wbsel=01.
REQ-026 mem_stall = load & ~m_rvalid & ~flush (combinational, no registered delay).
REQ-027 Per-cycle priority: flush > hold > load-wait > capture.
REQ-028 flush: wb_valid<=0, wb_regwr<=0; data registers, wb_sel, wb_rd hold value.
REQ-029 hold (no flush): every register holds; wait counter holds; misalign<=0.
REQ-030 load-wait (mem_stall=1, no hold/flush): wb_valid<=0, wb_regwr<=0 (bubble); wait counter +1, saturating at 255.
REQ-031 capture (otherwise): wb_a..wb_d, wb_sel, wb_rd, wb_valid<=m_valid loaded; wait counter<=0; one-cycle latency MEM->WB.
REQ-032 wb_regwr<=m_valid & m_regwr & (m_rd!=0) & ~misaligned.
REQ-033 Alignment: word requires offset 00; half requires offset[0]=0; byte any; lsize 11 treated as word.
REQ-034 Load data: byte = m_rdata[8*off+7:8*off]; half = m_rdata[16*off[1]+15:16*off[1]]; word = m_rdata; extended to 32 bits per m_lunsigned.
REQ-035 Misaligned load on capture: wb_b<=m_rdata unmodified, wb_regwr<=0, misalign<=1 for exactly one cycle; wb_valid<=1.
REQ-036 Non-load instructions ignore m_rvalid and never stall; wb_b captures aligned m_rdata anyway.
REQ-037 mem_timeout sets when wait counter reaches TIMEOUT while mem_stall=1; stays 1 until reset.
REQ-038 m_rvalid arriving with hold=1: no capture; mem_stall drops; upstream holds data; capture on first cycle hold=0.

Reset
REQ-039 rst_n=0 immediately clears: wb_a..wb_d=0, wb_sel=00, wb_rd=0, wb_regwr=0, wb_valid=0, misalign=0, mem_timeout=0, wait counter=0.
REQ-040 Reset during load-wait abandons the load; first post-reset capture behaves normally.
REQ-041 rst_n deassertion is synchronised externally; block needs no internal synchroniser.

Verification
REQ-042 ALU op m_alu=0x12345678, wbsel=00, rd=5, regwr=1 -> next cycle wb_a=0x12345678, wb_sel=00, wb_rd=5, wb_regwr=1, wb_valid=1.
REQ-043 Byte load off=3, m_rdata=0x80FF_0000, signed, rvalid=1 -> wb_b=0xFFFFFF80; unsigned -> wb_b=0x00000080.
REQ-044 Half load off=2, rvalid low 3 cycles -> mem_stall=1 for 3 cycles, 3 bubbles (wb_valid=0), then capture with wb_b per REQ-034.
REQ-045 Word load off=01 -> misalign pulse 1 cycle, wb_regwr=0, wb_valid=1, wb_b=m_rdata.
REQ-046 Load with rvalid held low, TIMEOUT=15 -> mem_timeout=1 after 15 wait cycles, remains 1 after rvalid; cleared only by rst_n=0.
REQ-047 flush asserted with hold and rvalid -> wb_valid=0, wb_regwr=0; rd=0 with regwr=1 -> wb_regwr=0.
